// File: rtl/simon_pkt_assembler.sv
// Purpose : collects a header byte plus PKT_BYTES-1 payload bytes into one packet for the SIMON core.
// Latency : newIN rises the cycle after the last byte is accepted; errPkt pulses one cycle after timeout.
// Backpress: byteReady drops while a finished packet waits in HOLD until the core pulses loadPkt.
//
// Ports:
//   clk       - system clock, all state changes on rising edge
//   R         - asynchronous active-high reset
//   byteIn    - incoming serial byte
//   byteValid - byteIn holds a valid byte
//   byteReady - block accepts a byte this cycle
//   in        - assembled packet, header in the MSB slot
//   newIN     - a complete packet is present on in
//   loadPkt   - packet core has latched in
//   errPkt    - one-cycle pulse: a partial packet was dropped on inter-byte timeout

module simon_pkt_assembler #(
  parameter int N         = 16,
  parameter int PKT_BYTES = 2 + (N / 2),
  parameter int TO        = 255
) (
  input  logic                      clk,
  input  logic                      R,
  input  logic [7:0]                byteIn,
  input  logic                      byteValid,
  output logic                      byteReady,
  output logic [PKT_BYTES-1:0][7:0] in,
  output logic                      newIN,
  input  logic                      loadPkt,
  output logic                      errPkt
);

  localparam int CW = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;
  localparam int IW = $clog2(TO + 2);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [CW-1:0]             r_cnt;
  logic [CW-1:0]             w_cnt_nxt;
  logic [IW-1:0]             r_idle;
  logic [IW-1:0]             w_idle_nxt;
  logic [PKT_BYTES-1:0][7:0] r_in;
  logic                      r_rdy;
  logic                      r_err;
  logic                      w_err_nxt;
  logic                      w_acc;
  logic                      w_wr;
  logic [CW-1:0]             w_wr_idx;

  // r_rdy is only ever 1 outside HOLD, so this alone gates acceptance.
  assign w_acc = byteValid & r_rdy;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idle_nxt  = r_idle;
    w_err_nxt   = 1'b0;
    w_wr        = 1'b0;
    w_wr_idx    = r_cnt;

    case (r_state)
      IDLE: begin
        w_idle_nxt = '0;
        // Bytes without bit7 set cannot start a packet and are silently dropped.
        if (w_acc && byteIn[7]) begin
          w_wr        = 1'b1;
          w_wr_idx    = CW'(PKT_BYTES - 1);
          w_cnt_nxt   = CW'(PKT_BYTES - 2);
          w_state_nxt = COLLECT;
        end
      end

      COLLECT: begin
        if (w_acc) begin
          w_wr       = 1'b1;
          w_wr_idx   = r_cnt;
          w_idle_nxt = '0;
          if (r_cnt == '0) begin
            w_state_nxt = HOLD;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end else if (r_idle == IW'(TO)) begin
          // This is the TO+1-th consecutive empty cycle: abandon the packet.
          w_state_nxt = IDLE;
          w_err_nxt   = 1'b1;
          w_idle_nxt  = '0;
          w_cnt_nxt   = '0;
        end else begin
          w_idle_nxt = r_idle + 1'b1;
        end
      end

      HOLD: begin
        w_idle_nxt = '0;
        if (loadPkt) begin
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_idle_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idle  <= '0;
      r_in    <= '0;
      r_rdy   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idle  <= w_idle_nxt;
      r_err   <= w_err_nxt;
      // Registered from the next state so ready is low for the whole HOLD
      // and rises on the first edge after reset release.
      r_rdy   <= (w_state_nxt != HOLD);
      if (w_wr) begin
        r_in[w_wr_idx] <= byteIn;
      end
    end
  end

  assign byteReady = r_rdy;
  assign in        = r_in;
  assign newIN     = (r_state == HOLD);
  assign errPkt    = r_err;

endmodule

// File: tb/tb_simon_pkt_assembler.sv
module tb_simon_pkt_assembler;

  localparam int PB = 10;
  localparam int PW = PB * 8;

  logic              clk = 1'b0;
  logic              R;
  logic [7:0]        byteIn;
  logic              byteValid;
  logic              byteReady;
  logic [PB-1:0][7:0] in;
  logic              newIN;
  logic              loadPkt;
  logic              errPkt;

  int                total = 0;
  int                bad = 0;
  logic [PW-1:0]     exp_q[$];
  logic [PW-1:0]     last_pkt = '0;
  logic              prev_new = 1'b0;
  int                err_cycles = 0;

  simon_pkt_assembler #(.N(16), .PKT_BYTES(PB), .TO(255)) dut (
    .clk       (clk),
    .R         (R),
    .byteIn    (byteIn),
    .byteValid (byteValid),
    .byteReady (byteReady),
    .in        (in),
    .newIN     (newIN),
    .loadPkt   (loadPkt),
    .errPkt    (errPkt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard: compare the packet on every rising newIN against the oldest expected one.
  always @(negedge clk) begin
    if (errPkt === 1'b1) err_cycles++;
    if (newIN === 1'b1 && prev_new !== 1'b1) begin
      chk("pkt_expected", PW'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("pkt_data", in, exp_q.pop_front());
    end
    prev_new = newIN;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Called on a negedge; returns on the negedge right after the accepting posedge.
  task automatic send(input logic [7:0] b);
    int n = 0;
    byteIn    = b;
    byteValid = 1'b1;
    while (byteReady !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_ready_timeout", n, 0);
    @(negedge clk);
  endtask

  task automatic send_pkt(input logic [PW-1:0] p, input int gap);
    exp_q.push_back(p);
    last_pkt = p;
    for (int i = 0; i < PB; i++) begin
      send(p[(PB-1-i)*8 +: 8]);
      if (gap > 0 && i < PB - 1) begin
        byteValid = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
    byteValid = 1'b0;
  endtask

  task automatic release_pkt();
    loadPkt = 1'b1;
    @(negedge clk);
    loadPkt = 1'b0;
    chk("rel_newIN", newIN, 0);
    chk("rel_ready", byteReady, 1);
    chk("rel_in_kept", in, last_pkt);
  endtask

  initial begin
    int k;
    logic [PW-1:0] p6;
    R = 1'b1; byteValid = 1'b0; loadPkt = 1'b0; byteIn = 8'h00;
    #2;
    chk("rst_ready", byteReady, 0);
    chk("rst_newIN", newIN, 0);
    chk("rst_err", errPkt, 0);
    chk("rst_in", in, 0);
    @(negedge clk);
    R = 1'b0;
    #1;
    chk("rel_ready_low", byteReady, 0);
    @(negedge clk);
    chk("ready_after_edge", byteReady, 1);

    // Back-to-back packet.
    send_pkt(80'hE0001918111009080100, 0);
    chk("p1_newIN", newIN, 1);
    chk("p1_ready", byteReady, 0);

    // Valid held high during HOLD with a header-like byte waiting.
    byteIn = 8'hC5; byteValid = 1'b1;
    repeat (3) @(negedge clk);
    chk("hold_in", in, 80'hE0001918111009080100);
    chk("hold_newIN", newIN, 1);
    chk("hold_ready", byteReady, 0);
    release_pkt();
    send_pkt(80'hC5010203040506070809, 0);
    chk("p2_newIN", newIN, 1);
    release_pkt();

    // Non-header byte in IDLE is dropped.
    send(8'h5A);
    byteValid = 1'b0;
    chk("drop_in", in, 80'hC5010203040506070809);
    chk("drop_newIN", newIN, 0);
    send_pkt(80'hC0016565687721403F21, 0);
    chk("p3_newIN", newIN, 1);
    release_pkt();

    // One idle cycle between bytes: must not time out.
    send_pkt(80'h8F1E2D3C4B5A69788796, 1);
    chk("p4_newIN", newIN, 1);
    release_pkt();

    // Inter-byte timeout.
    send(8'hE0); send(8'h00); send(8'h19);
    byteValid = 1'b0;
    k = 0;
    while (errPkt !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("to_cycles", k, 256);
    chk("to_newIN", newIN, 0);
    @(negedge clk);
    chk("to_pulse_width", errPkt, 0);
    chk("to_ready", byteReady, 1);
    send_pkt(80'hA1B2C3D4E5F601020304, 0);
    chk("p5_newIN", newIN, 1);
    release_pkt();

    // Asynchronous reset mid-packet.
    p6 = 80'hE0001918111009080100;
    for (int i = 0; i < 6; i++) send(p6[(PB-1-i)*8 +: 8]);
    byteValid = 1'b0;
    #3;
    R = 1'b1;
    #1;
    chk("arst_ready", byteReady, 0);
    chk("arst_newIN", newIN, 0);
    chk("arst_err", errPkt, 0);
    chk("arst_in", in, 0);
    @(negedge clk);
    R = 1'b0;
    @(negedge clk);
    chk("arst_ready_back", byteReady, 1);
    send_pkt(80'hFF00FF00FF00FF00FF00, 0);
    chk("p7_newIN", newIN, 1);
    release_pkt();

    repeat (3) @(negedge clk);
    chk("err_pulse_count", err_cycles, 1);
    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
